// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
// Address width, byte-offset width, FSM state encoding and the address-legality check.
package mem_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned OFFS_W = 2;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StAccess,
      StDone
   } state_t;

   // Illegal when not word aligned or when any bit above the word index is set.
   function automatic logic addr_bad(input logic [ADDR_W-1:0] a, input int unsigned depth_log2);
      return (a[OFFS_W-1:0] != '0) || ((a >> (depth_log2 + OFFS_W)) != '0);
   endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, word wide, with write enable and registered read.
// Read-first: a same-edge write is not visible on rdata until the next read.
module ram_sp #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYC wait states, then a
// single RAM access and a one-cycle ack (with err for illegal addresses).
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned WAIT_CYC   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              err,
   output logic              busy
);

   localparam int unsigned CntW = 4;

   state_t                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  we_q;
   logic                  err_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W-1:0]     rdata_q;
   logic [DATA_W-1:0]     ram_rdata;
   logic [DEPTH_LOG2-1:0] ram_idx;
   logic                  ram_we;
   logic                  accept;

   assign accept = (state_q == StIdle) && req;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               cnt_d   = CntW'(WAIT_CYC);
               state_d = (WAIT_CYC == 0) ? StAccess : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               state_d = StAccess;
            end
         end
         StAccess: state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs. The RAM write is gated by rst_n so a reset on the access edge wins.
   always_comb begin
      ack    = (state_q == StDone);
      err    = (state_q == StDone) && err_q;
      busy   = (state_q != StIdle);
      ram_we = (state_q == StAccess) && we_q && !err_q && rst_n;
   end

   // Request latch and read-data register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            we_q    <= we;
            err_q   <= addr_bad(addr, DEPTH_LOG2);
            idx_q   <= addr[DEPTH_LOG2+OFFS_W-1:OFFS_W];
            wdata_q <= wdata;
         end
         if (state_q == StAccess) begin
            if (err_q) begin
               rdata_q <= '0;
            end else if (!we_q) begin
               rdata_q <= ram_rdata;
            end
         end
      end
   end

   // Steer the RAM at the incoming index while idle so its registered read is
   // already valid in the access cycle, even with zero wait states.
   assign ram_idx = (state_q == StIdle) ? addr[DEPTH_LOG2+OFFS_W-1:OFFS_W] : idx_q;
   assign rdata   = rdata_q;

   ram_sp #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_idx),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

endmodule
